// File: rtl/gfx_pkg.sv
// Shared graphics definitions: colour-depth codes, address-to-coordinate
// FSM states and the bits-per-pixel lookup used by the address blocks.
package gfx_pkg;

  localparam logic [1:0] BPP8  = 2'd0;
  localparam logic [1:0] BPP16 = 2'd1;
  localparam logic [1:0] BPP24 = 2'd2;
  localparam logic [1:0] BPP32 = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DIV,
    FIX
  } a2c_state_t;

  // Bits per pixel for a colour-depth code; unknown codes fall back to 16.
  function automatic logic [5:0] bpp_bits(input logic [1:0] color_depth);
    logic [5:0] bits;
    case (color_depth)
      BPP8:    bits = 6'd8;
      BPP16:   bits = 6'd16;
      BPP24:   bits = 6'd24;
      BPP32:   bits = 6'd32;
      default: bits = 6'd16;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/gfx_serial_divider.sv
// Serial restoring divider: one quotient bit per clock, MSB first,
// exactly DW clocks after start.
module gfx_serial_divider #(
  parameter int unsigned DW = 28,
  parameter int unsigned VW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quot,
  output logic [VW-1:0] rem
);

  localparam int unsigned CW = $clog2(DW + 1);

  logic [DW-1:0] q;
  logic [VW-1:0] r;
  logic [VW-1:0] d;
  logic [CW-1:0] cnt;
  logic [VW:0]   trial;
  logic          ge;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    trial = {r, q[DW-1]};
    ge    = (trial >= {1'b0, d});
  end

  // Load operands on start, then shift quotient bits into q while dividend
  // bits shift out of its top end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      r   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (start) begin
      q   <= dividend;
      r   <= '0;
      d   <= divisor;
      cnt <= CW'(DW);
    end else if (cnt != '0) begin
      q   <= {q[DW-2:0], ge};
      r   <= ge ? VW'(trial - {1'b0, d}) : VW'(trial);
      cnt <= cnt - 1'b1;
    end
  end

  // done is high during the final iteration so the owner leaves its wait
  // state on the same edge that writes the last quotient bit.
  assign done = (cnt == CW'(1));
  assign quot = q;
  assign rem  = r;

endmodule

// File: rtl/gfx_address_to_coord.sv
// Maps a strip-aligned bitmap address plus in-strip bit position back to
// pixel (x,y): y = strip index / strips-per-line, x from the remainder.
module gfx_address_to_coord
  import gfx_pkg::*;
#(
  parameter  int unsigned SW = 128,
  localparam int unsigned BN = $clog2(SW) - 1,
  localparam int unsigned SB = $clog2(SW / 8),
  localparam int unsigned DW = 32 - SB
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [31:0] base_address_i,
  input  logic [1:0]  color_depth_i,
  input  logic [15:0] bmp_width_i,
  input  logic [31:0] address_i,
  input  logic [BN:0] mb_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] x_coord_o,
  output logic [15:0] y_coord_o
);

  a2c_state_t state, state_next;

  logic [31:0]   base_r;
  logic [31:0]   addr_r;
  logic [1:0]    depth_r;
  logic [15:0]   width_r;
  logic [BN:0]   mb_r;
  logic [BN:0]   pix_r;
  logic          err_r;

  logic [5:0]    bits;
  logic [32:0]   off;
  logic [DW-1:0] sidx;
  logic [9:0]    nstr;
  logic [8:0]    mbx;
  logic [BN:0]   pix_c;
  logic [6:0]    pps;
  logic          setup_err;

  logic          div_start;
  logic          div_done;
  logic [DW-1:0] quot;
  logic [9:0]    rem;

  logic          fix_err;
  logic [15:0]   x_calc;

  // Setup arithmetic on the captured request: offset, strip index,
  // strips per line and pixel-within-strip.
  always_comb begin
    bits      = bpp_bits(depth_r);
    off       = {1'b0, addr_r} - {1'b0, base_r};
    sidx      = DW'(off[31:0] >> SB);
    nstr      = 10'(({6'b0, width_r} * {16'b0, bits}) >> $clog2(SW));
    mbx       = 9'(mb_r);
    pix_c     = '0;
    pps       = '0;
    case (depth_r)
      BPP8:    begin pix_c = (BN+1)'(mbx >> 3);     pps = 7'(SW / 8);  end
      BPP24:   begin pix_c = (BN+1)'(mbx / 9'd24);  pps = 7'(SW / 24); end
      BPP32:   begin pix_c = (BN+1)'(mbx >> 5);     pps = 7'(SW / 32); end
      default: begin pix_c = (BN+1)'(mbx >> 4);     pps = 7'(SW / 16); end
    endcase
    setup_err = off[32] | (nstr == '0) | (9'(pix_c) >= 9'(pps));
  end

  // Final coordinate assembly from the divider result.
  always_comb begin
    fix_err = err_r | (quot > DW'(16'hFFFF));
    x_calc  = 16'(17'(rem) * 17'(pps) + 17'(pix_r));
  end

  gfx_serial_divider #(
    .DW (DW),
    .VW (10)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sidx),
    .divisor  (nstr),
    .done     (div_done),
    .quot     (quot),
    .rem      (rem)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and divider launch.
  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    case (state)
      IDLE:  if (req_i) state_next = SETUP;
      SETUP: begin
        if (setup_err) begin
          state_next = FIX;
        end else begin
          div_start  = 1'b1;
          state_next = DIV;
        end
      end
      DIV:   if (div_done) state_next = FIX;
      FIX:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, setup results and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r    <= '0;
      addr_r    <= '0;
      depth_r   <= '0;
      width_r   <= '0;
      mb_r      <= '0;
      pix_r     <= '0;
      err_r     <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      x_coord_o <= '0;
      y_coord_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            base_r  <= base_address_i;
            addr_r  <= address_i;
            depth_r <= color_depth_i;
            width_r <= bmp_width_i;
            mb_r    <= mb_i;
            busy_o  <= 1'b1;
          end
        end
        SETUP: begin
          err_r <= setup_err;
          pix_r <= pix_c;
        end
        FIX: begin
          done_o    <= 1'b1;
          busy_o    <= 1'b0;
          err_o     <= fix_err;
          x_coord_o <= fix_err ? '0 : x_calc;
          y_coord_o <= fix_err ? '0 : quot[15:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_address_to_coord.sv
// Self-checking bench for gfx_address_to_coord (SW=128) against an
// arithmetic reference model.
module tb_gfx_address_to_coord;
  import gfx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] base = '0;
  logic [1:0]  depth = '0;
  logic [15:0] width = '0;
  logic [31:0] addr = '0;
  logic [6:0]  mb = '0;
  logic        busy, done, err;
  logic [15:0] x_coord, y_coord;

  int errors = 0;
  int checks = 0;

  gfx_address_to_coord #(.SW(128)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req),
    .base_address_i (base),
    .color_depth_i  (depth),
    .bmp_width_i    (width),
    .address_i      (addr),
    .mb_i           (mb),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .x_coord_o      (x_coord),
    .y_coord_o      (y_coord)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned bits_of(input logic [1:0] d);
    return (d == 2'd0) ? 8 : (d == 2'd1) ? 16 : (d == 2'd2) ? 24 : 32;
  endfunction

  // Reference: strip index = byte offset / 16, y = index / strips-per-line.
  function automatic void ref_model(input logic [1:0] d, input logic [15:0] w,
                                    input logic [31:0] b, input logic [31:0] a,
                                    input logic [6:0] m,
                                    output int unsigned ex, output int unsigned ey,
                                    output bit ee, output int unsigned elat);
    int unsigned bpp, pps, nstr, pix;
    longint off, sidx;
    bpp  = bits_of(d);
    pps  = 128 / bpp;
    nstr = ((int'(w) * bpp) / 128) % 1024;
    pix  = int'(m) / bpp;
    off  = longint'(a) - longint'(b);
    ex = 0; ey = 0; ee = 0; elat = 30;
    if (off < 0 || nstr == 0 || pix >= pps) begin
      ee = 1; elat = 2;
      return;
    end
    sidx = off / 16;
    if (sidx / nstr > 65535) begin
      ee = 1;
      return;
    end
    ey = int'(sidx / nstr);
    ex = int'(sidx % nstr) * pps + pix;
  endfunction

  task automatic convert(input logic [1:0] d, input logic [15:0] w, input logic [31:0] b,
                         input logic [31:0] a, input logic [6:0] m,
                         output logic [15:0] ox, output logic [15:0] oy,
                         output logic oe, output int lat);
    bit got;
    @(negedge clk);
    depth = d; width = w; base = b; addr = a; mb = m; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("busy_after_accept", busy, 1);
    got = 0; lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; got = 1;
        break;
      end
    end
    if (!got) check("done_timeout", 0, 1);
    ox = x_coord; oy = y_coord; oe = err;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("x_hold", x_coord, ox);
  endtask

  task automatic run_vs_model(input string tag, input logic [1:0] d, input logic [15:0] w,
                              input logic [31:0] b, input logic [31:0] a, input logic [6:0] m);
    int unsigned ex, ey, elat;
    bit ee;
    logic [15:0] ox, oy;
    logic oe;
    int lat;
    ref_model(d, w, b, a, m, ex, ey, ee, elat);
    convert(d, w, b, a, m, ox, oy, oe, lat);
    check({tag, "_x"}, ox, ex);
    check({tag, "_y"}, oy, ey);
    check({tag, "_err"}, oe, ee);
    check({tag, "_lat"}, lat, elat);
  endtask

  initial begin
    logic [15:0] ox, oy;
    logic oe;
    int lat;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_x", x_coord, 0);
    check("rst_y", y_coord, 0);
    rst_n = 1'b1;

    // Directed cases with hand-derived results
    convert(BPP16, 16'd640, 32'h1000, 32'h1F50, 7'd32, ox, oy, oe, lat);
    check("c16_x", ox, 42); check("c16_y", oy, 3); check("c16_err", oe, 0); check("c16_lat", lat, 30);
    convert(BPP24, 16'd800, 32'h0, 32'h5E30, 7'd72, ox, oy, oe, lat);
    check("c24_x", ox, 38); check("c24_y", oy, 10); check("c24_err", oe, 0); check("c24_lat", lat, 30);
    convert(BPP16, 16'd640, 32'h1000, 32'h0FF0, 7'd0, ox, oy, oe, lat);
    check("uflow_err", oe, 1); check("uflow_x", ox, 0); check("uflow_y", oy, 0); check("uflow_lat", lat, 2);
    convert(BPP8, 16'd4, 32'h0, 32'h100, 7'd0, ox, oy, oe, lat);
    check("nstr0_err", oe, 1); check("nstr0_lat", lat, 2);
    convert(BPP24, 16'd800, 32'h0, 32'h5E30, 7'd120, ox, oy, oe, lat);
    check("pix_err", oe, 1); check("pix_x", ox, 0); check("pix_lat", lat, 2);
    // y overflow: nstr=1, strip index 0x20000 -> quotient exceeds 16 bits
    convert(BPP32, 16'd4, 32'h0, 32'h0020_0000, 7'd0, ox, oy, oe, lat);
    check("yovf_err", oe, 1); check("yovf_y", oy, 0); check("yovf_lat", lat, 30);

    // req held high; inputs changed mid-op; second request accepted right after done
    begin
      int dn, t1, t2;
      logic [15:0] xa, ya, xb, yb;
      dn = 0; t1 = 0; t2 = 0; xa = '0; ya = '0; xb = '0; yb = '0;
      @(negedge clk);
      depth = BPP16; width = 16'd640; base = 32'h1000; addr = 32'h1F50; mb = 7'd32; req = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 80; i++) begin
        @(negedge clk);
        if (i == 5) begin
          depth = BPP24; width = 16'd800; base = 32'h0; addr = 32'h5E30; mb = 7'd72;
        end
        if (done) begin
          dn++;
          if (dn == 1) begin
            t1 = i; xa = x_coord; ya = y_coord;
          end else begin
            t2 = i; xb = x_coord; yb = y_coord; req = 1'b0;
            break;
          end
        end
      end
      req = 1'b0;
      check("held_first_done", t1, 30);
      check("held_second_done", t2, 61);
      check("held_xa", xa, 42); check("held_ya", ya, 3);
      check("held_xb", xb, 38); check("held_yb", yb, 10);
      @(negedge clk);
      check("held_no_third", busy, 0);
    end

    // Reset asserted during the divide: outputs clear, no done afterwards
    begin
      int dn;
      @(negedge clk);
      depth = BPP16; width = 16'd640; base = 32'h1000; addr = 32'h1F50; mb = 7'd32; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_x", x_coord, 0);
      check("abort_y", y_coord, 0);
      check("abort_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) dn++;
      end
      check("abort_no_done", dn, 0);
      convert(BPP16, 16'd640, 32'h1000, 32'h1F50, 7'd32, ox, oy, oe, lat);
      check("after_abort_x", ox, 42); check("after_abort_y", oy, 3); check("after_abort_lat", lat, 30);
    end

    // Round trip: forward address computed from random pixel, then recovered
    for (int n = 0; n < 30; n++) begin
      logic [1:0] d;
      int unsigned bpp, pps, nstr, px, py, sidx, w;
      logic [31:0] b, a;
      logic [6:0] m;
      d    = 2'($urandom_range(0, 3));
      bpp  = bits_of(d);
      pps  = 128 / bpp;
      w    = $urandom_range(64, 4000);
      nstr = (w * bpp) / 128;
      px   = $urandom_range(0, nstr * pps - 1);
      py   = $urandom_range(0, 1000);
      sidx = py * nstr + px / pps;
      b    = $urandom & 32'h00FF_FFFF;
      a    = b + sidx * 16 + $urandom_range(0, 15);
      m    = 7'((px % pps) * bpp + $urandom_range(0, bpp - 1));
      convert(d, 16'(w), b, a, m, ox, oy, oe, lat);
      check("rt_x", ox, px);
      check("rt_y", oy, py);
      check("rt_err", oe, 0);
    end

    // Random requests against the reference model, including error cases
    for (int n = 0; n < 30; n++) begin
      logic [1:0] d;
      logic [15:0] w;
      logic [31:0] b, a;
      int sel;
      d   = 2'($urandom_range(0, 3));
      w   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      b   = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0)      a = b - $urandom_range(1, 64);
      else if (sel == 1) a = $urandom;
      else               a = b + $urandom_range(0, 1 << 18);
      run_vs_model("rnd", d, w, b, a, 7'($urandom_range(0, 127)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
